vga_timing_gen: RTL

Raster timing generator; the producer side of the x/y pixel-coordinate interface consumed by the pattern and trace renderers.
- Free-runs horizontal and vertical counters at pixel-clock rate.
- Emits x/y coordinates, hsync/vsync, a visible-area flag and line/frame start strobes.
- Sits between the pixel clock and every renderer, and drives the VGA connector syncs directly.

---
 rtl/vga_timing_gen.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing generator: free-running x/y counters with registered syncs, visible flag and strobes.
// Optional VGA_FRAME_COUNT_EN adds an 8-bit frame_count output that ticks with frame_start.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [10:0] x,
    output logic [9:0]  y,
    output logic        hsync,
    output logic        vsync,
    output logic        visible,
    output logic        line_start,
`ifdef VGA_FRAME_COUNT_EN
    output logic [7:0]  frame_count,
`endif
    output logic        frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] H_LAST      = 11'(H_TOTAL - 1);
    localparam logic [11:0] H_FP_START  = 12'(H_VISIBLE);
    localparam logic [11:0] H_SYN_START = 12'(H_VISIBLE + H_FRONT);
    localparam logic [11:0] H_BP_START  = 12'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam bit          H_HAS_FP    = (H_FRONT > 0);
    localparam bit          H_HAS_SYN   = (H_SYNC > 0);
    localparam bit          H_HAS_BP    = (H_BACK > 0);

    localparam logic [9:0]  V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [10:0] V_FP_START  = 11'(V_VISIBLE);
    localparam logic [10:0] V_SYN_START = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] V_BP_START  = 11'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam bit          V_HAS_FP    = (V_FRONT > 0);
    localparam bit          V_HAS_SYN   = (V_SYNC > 0);
    localparam bit          V_HAS_BP    = (V_BACK > 0);

    if (H_TOTAL > 2048 || H_TOTAL < 1) begin : g_bad_h_total
        $error("vga_timing_gen: H_TOTAL out of range 1..2048");
    end
    if (V_TOTAL > 1024 || V_TOTAL < 1) begin : g_bad_v_total
        $error("vga_timing_gen: V_TOTAL out of range 1..1024");
    end

    typedef enum logic [1:0] {H_ACT, H_FP, H_SYN, H_BP} h_state_t;
    typedef enum logic [1:0] {V_ACT, V_FP, V_SYN, V_BP} v_state_t;

    logic [10:0] x_q, x_d;
    logic [9:0]  y_q, y_d;
    h_state_t    h_state_q, h_state_d;
    v_state_t    v_state_q, v_state_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        visible_q, visible_d;
    logic        line_start_q, line_start_d;
    logic        frame_start_q, frame_start_d;
    logic        x_wrap;
`ifdef VGA_FRAME_COUNT_EN
    logic [7:0]  frame_count_q, frame_count_d;
`endif

    // Phases change when the next coordinate lands on a phase start; checking later phases
    // first lets a zero-width phase be skipped without a dead cycle.
    always_comb begin
        x_wrap    = (x_q == H_LAST);
        x_d       = x_wrap ? 11'd0 : x_q + 11'd1;
        y_d       = y_q;
        h_state_d = h_state_q;
        v_state_d = v_state_q;

        if (x_d == 11'd0)
            h_state_d = H_ACT;
        else if (H_HAS_BP && {1'b0, x_d} == H_BP_START)
            h_state_d = H_BP;
        else if (H_HAS_SYN && {1'b0, x_d} == H_SYN_START)
            h_state_d = H_SYN;
        else if (H_HAS_FP && {1'b0, x_d} == H_FP_START)
            h_state_d = H_FP;

        if (x_wrap) begin
            y_d = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
            if (y_d == 10'd0)
                v_state_d = V_ACT;
            else if (V_HAS_BP && {1'b0, y_d} == V_BP_START)
                v_state_d = V_BP;
            else if (V_HAS_SYN && {1'b0, y_d} == V_SYN_START)
                v_state_d = V_SYN;
            else if (V_HAS_FP && {1'b0, y_d} == V_FP_START)
                v_state_d = V_FP;
        end

        hsync_d       = (h_state_d == H_SYN) ? HSYNC_POL : ~HSYNC_POL;
        vsync_d       = (v_state_d == V_SYN) ? VSYNC_POL : ~VSYNC_POL;
        visible_d     = (h_state_d == H_ACT) && (v_state_d == V_ACT);
        line_start_d  = x_wrap;
        frame_start_d = x_wrap && (y_q == V_LAST);
`ifdef VGA_FRAME_COUNT_EN
        frame_count_d = frame_start_d ? frame_count_q + 8'd1 : frame_count_q;
`endif
    end

    // Reset parks the counters on the last pixel so the first free-running edge lands on 0,0.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            x_q           <= H_LAST;
            y_q           <= V_LAST;
            h_state_q     <= H_BP;
            v_state_q     <= V_BP;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            visible_q     <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
`ifdef VGA_FRAME_COUNT_EN
            frame_count_q <= 8'd0;
`endif
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            h_state_q     <= h_state_d;
            v_state_q     <= v_state_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            visible_q     <= visible_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
`ifdef VGA_FRAME_COUNT_EN
            frame_count_q <= frame_count_d;
`endif
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign visible     = visible_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
`ifdef VGA_FRAME_COUNT_EN
    assign frame_count = frame_count_q;
`endif

endmodule
